// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer
//
// Walks a register table and writes each entry to an OV7670 camera over SCCB
// by driving a byte-level I2C master. Each entry is one three-byte write:
// device id 8'h42, register address, register value. After the init table
// is written the block sits in DONE and accepts runtime single-register
// writes. NACKed transactions are retried a bounded number of times.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   tbl_addr[7:0]    index of the table entry being written
//   tbl_data[15:0]   table word for tbl_addr: [15:8] reg address, [7:0] value
//   start, stop      one-cycle pulses that open/close an SCCB transaction
//   wr_data[7:0]     byte handed to the I2C master, 0 when not presenting
//   ack[1:0]         ack[1] strobes at the 9th bit, ack[0] 1=ACK 0=NACK
//   i2c_idle         I2C master is idle
//   upd_req/addr/data runtime write request
//   upd_ack          runtime request accepted
//   done             init table fully written
//   busy             a transaction (START..GAP) is in progress
//   err, err_index   sticky retry-exhausted flag and failing index
//                    (8'hFF for a runtime write)
//   dbg_state[2:0]   FSM state: 0 BOOT, 1 START, 2 ADDR, 3 DATA, 4 STOP,
//                    5 GAP, 6 DONE, 7 ERR
//
// Runtime handshake: upd_req is a valid that the requester holds, together
// with upd_addr/upd_data, until it sees upd_ack. upd_ack is high only in
// the cycle where the request is latched (DONE state, upd_req high), so one
// request is taken per transaction and a held request is never lost.

module ov7670_cfg_sequencer #(
  parameter int unsigned MSG_LAST    = 78,
  parameter int unsigned BOOT_CYCLES = 67108864,
  parameter int unsigned GAP_CYCLES  = 65536,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        start,
  output logic        stop,
  output logic [7:0]  wr_data,
  input  logic [1:0]  ack,
  input  logic        i2c_idle,
  input  logic        upd_req,
  input  logic [7:0]  upd_addr,
  input  logic [7:0]  upd_data,
  output logic        upd_ack,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_index,
  output logic [2:0]  dbg_state
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [26:0]   BOOT_LAST = 27'(BOOT_CYCLES - 1);
  localparam logic [26:0]   GAP_LAST  = 27'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_SAT = RW'(MAX_RETRY + 1);
  localparam logic [7:0]    DEV_ID    = 8'h42;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  state_e        state_q;
  logic [26:0]   cnt_q;
  logic [7:0]    index_q;
  logic [RW-1:0] retry_q;
  logic          nack_q;      // last transaction ended on a NACK
  logic          rt_q;        // current transaction is a runtime write
  logic [7:0]    rt_addr_q;
  logic [7:0]    rt_data_q;
  logic          start_q;
  logic          stop_q;
  logic [7:0]    wr_data_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    err_index_q;

  logic [RW-1:0] retry_d;
  logic [7:0]    addr_byte_d;
  logic [7:0]    data_byte_d;
  logic          ack_ok;
  logic          ack_nack;

  assign ack_ok      = (ack == 2'b11);
  assign ack_nack    = (ack == 2'b10);
  // Saturating increment keeps the counter from wrapping back under the limit.
  assign retry_d     = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
  assign addr_byte_d = rt_q ? rt_addr_q : tbl_data[15:8];
  assign data_byte_d = rt_q ? rt_data_q : tbl_data[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      cnt_q       <= '0;
      index_q     <= '0;
      retry_q     <= '0;
      nack_q      <= 1'b0;
      rt_q        <= 1'b0;
      rt_addr_q   <= '0;
      rt_data_q   <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      // Pulses and the presented byte last exactly one cycle unless re-armed.
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      wr_data_q <= '0;
      case (state_q)
        S_BOOT: begin
          if (cnt_q == BOOT_LAST) begin
            cnt_q     <= '0;
            index_q   <= '0;
            state_q   <= S_START;
            start_q   <= 1'b1;
            wr_data_q <= DEV_ID;
          end else begin
            cnt_q <= cnt_q + 27'd1;
          end
        end
        S_START: state_q <= S_ADDR;
        S_ADDR, S_DATA, S_STOP: begin
          if (ack_ok) begin
            if (state_q == S_ADDR) begin
              wr_data_q <= addr_byte_d;
              state_q   <= S_DATA;
            end else if (state_q == S_DATA) begin
              wr_data_q <= data_byte_d;
              state_q   <= S_STOP;
            end else begin
              stop_q  <= 1'b1;
              retry_q <= '0;
              nack_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_GAP;
            end
          end else if (ack_nack) begin
            stop_q  <= 1'b1;
            retry_q <= retry_d;
            nack_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q != GAP_LAST) begin
            cnt_q <= cnt_q + 27'd1;
          end else if (i2c_idle) begin
            cnt_q <= '0;
            if (nack_q) begin
              if (retry_q > RETRY_MAX) begin
                err_q   <= 1'b1;
                retry_q <= '0;
                nack_q  <= 1'b0;
                if (rt_q) begin
                  err_index_q <= 8'hFF;
                  rt_q        <= 1'b0;
                  state_q     <= S_DONE;
                end else begin
                  err_index_q <= index_q;
                  state_q     <= S_ERR;
                end
              end else begin
                state_q   <= S_START;
                start_q   <= 1'b1;
                wr_data_q <= DEV_ID;
              end
            end else if (rt_q) begin
              rt_q    <= 1'b0;
              state_q <= S_DONE;
            end else if (index_q == 8'(MSG_LAST)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              index_q   <= index_q + 8'd1;
              state_q   <= S_START;
              start_q   <= 1'b1;
              wr_data_q <= DEV_ID;
            end
          end
        end
        S_DONE: begin
          if (upd_req) begin
            rt_q      <= 1'b1;
            rt_addr_q <= upd_addr;
            rt_data_q <= upd_data;
            state_q   <= S_START;
            start_q   <= 1'b1;
            wr_data_q <= DEV_ID;
          end
        end
        S_ERR: state_q <= S_ERR;
        default: state_q <= S_BOOT;
      endcase
    end
  end

  // Accept strobe is combinational so it coincides with the latching edge.
  assign upd_ack   = rst_n && (state_q == S_DONE) && upd_req;
  assign busy      = (state_q == S_START) || (state_q == S_ADDR) ||
                     (state_q == S_DATA)  || (state_q == S_STOP) ||
                     (state_q == S_GAP);
  assign tbl_addr  = index_q;
  assign start     = start_q;
  assign stop      = stop_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_index = err_index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Testbench for ov7670_cfg_sequencer: an SCCB slave responder logs every
// byte the sequencer hands over; a transaction-level model builds the byte
// stream the table and the NACK plan should produce.

module tb_ov7670_cfg_sequencer;

  localparam int ML  = 5;
  localparam int BC  = 16;
  localparam int GC  = 8;
  localparam int MR  = 3;
  localparam int LIM = 4000;
  localparam logic [2:0] ST_BOOT = 3'd0, ST_ADDR = 3'd2, ST_DONE = 3'd6,
                         ST_ERR = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  tbl_addr, wr_data, upd_addr, upd_data, err_index;
  logic [15:0] tbl_data;
  logic        start, stop, i2c_idle, upd_req, upd_ack, done, busy, err;
  logic [1:0]  ack;
  logic [2:0]  dbg_state;
  logic [15:0] tbl_mem [0:255];

  assign tbl_data = tbl_mem[tbl_addr];

  ov7670_cfg_sequencer #(
    .MSG_LAST(ML), .BOOT_CYCLES(BC), .GAP_CYCLES(GC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .stop(stop), .wr_data(wr_data), .ack(ack),
    .i2c_idle(i2c_idle), .upd_req(upd_req), .upd_addr(upd_addr),
    .upd_data(upd_data), .upd_ack(upd_ack), .done(done), .busy(busy),
    .err(err), .err_index(err_index), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // NACK plan consumed by the slave
  int nack_entry = -1;
  int nack_k = 0;
  int nack_left = 0;
  bit nack_rt = 1'b0;
  bit hold5 = 1'b0;

  int ack_pulses = 0;
  int early_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one table/runtime entry, MR+1 attempts at most.
  // A NACK on byte k (0 id, 1 address, 2 value) means bytes 0..k were sent.
  task automatic model_entry(input logic [7:0] a, input logic [7:0] v,
                             input int k, input int n_nack, output bit failed);
    failed = 1'b1;
    for (int att = 0; att <= MR; att++) begin
      exp_q.push_back(8'h42);
      if (att < n_nack) begin
        if (k >= 1) exp_q.push_back(a);
        if (k >= 2) exp_q.push_back(v);
      end else begin
        exp_q.push_back(a);
        exp_q.push_back(v);
        failed = 1'b0;
        break;
      end
    end
  endtask

  task automatic model_init(input int ne, input int k, input int nn);
    bit f;
    for (int i = 0; i <= ML; i++) begin
      model_entry(tbl_mem[i][15:8], tbl_mem[i][7:0], k, (i == ne) ? nn : 0, f);
      if (f) break;
    end
  endtask

  task automatic check_log(input string tag);
    int n;
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte[%0d]", tag, i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
  endtask

  // SCCB slave: acks the three bytes of each transaction after a random delay
  task automatic run_tx();
    bit nk, is_rt, aborted;
    is_rt = done;
    obs_q.push_back(wr_data);
    i2c_idle = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 3 && !aborted; k++) begin
      nk = (nack_left > 0) && (k == nack_k) &&
           (is_rt ? nack_rt : (int'(tbl_addr) == nack_entry));
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1 ack = {1'b1, !nk};
      @(posedge clk);
      #1 ack = 2'b00;
      @(negedge clk);
      if (nk) begin
        nack_left--;
        chk("nack_stop", stop, 1);
        aborted = 1'b1;
      end else if (k < 2) begin
        obs_q.push_back(wr_data);
        chk("mid_stop", stop, 0);
      end else begin
        chk("end_stop", stop, 1);
      end
    end
    // stray ack inside GAP must have no effect
    repeat (2) @(posedge clk);
    #1 ack = 2'b11;
    @(posedge clk);
    #1 ack = 2'b00;
    i2c_idle = 1'b1;
  endtask

  initial begin
    ack = 2'b00;
    i2c_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && !(hold5 && tbl_addr == 8'd5)) run_tx();
    end
  end

  always @(negedge clk) begin
    if (upd_ack === 1'b1) begin
      ack_pulses++;
      if (done !== 1'b1) early_ack++;
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    nack_entry = -1; nack_k = 0; nack_left = 0; nack_rt = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {start, stop, upd_ack, done, busy, err}, 0);
    chk("rst_bytes", {wr_data, err_index, tbl_addr}, 0);
    chk("rst_state", dbg_state, ST_BOOT);
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int i;
    for (i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (dbg_state === s) break;
    end
    chk({tag, "_reached"}, i < LIM, 1);
  endtask

  task automatic wait_upd_ack(input string tag);
    int i;
    for (i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (upd_ack === 1'b1) break;
    end
    chk({tag, "_upd_ack"}, i < LIM, 1);
    chk({tag, "_ack_done"}, done, 1);
    @(posedge clk);
    #1 upd_req = 1'b0;
  endtask

  task automatic issue_upd(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    upd_addr = a;
    upd_data = d;
    upd_req = 1'b1;
  endtask

  initial begin
    bit f;
    int boot_cnt;
    logic [7:0] ra, rd;
    for (int i = 0; i < 256; i++) tbl_mem[i] = 16'($urandom);
    upd_req = 1'b0; upd_addr = '0; upd_data = '0;

    // S1: nominal init, runtime request raised during BOOT
    do_reset(3);
    ack_pulses = 0; early_ack = 0;
    upd_addr = 8'h55; upd_data = 8'h40; upd_req = 1'b1;
    model_init(-1, 0, 0);
    model_entry(8'h55, 8'h40, 0, 0, f);
    wait_upd_ack("s1");
    wait_state(ST_DONE, "s1_done");
    check_log("s1");
    chk("s1_flags", {done, err, busy}, 3'b100);
    chk("s1_ack_pulses", ack_pulses, 1);
    chk("s1_early_ack", early_ack, 0);

    // S2: one NACK on the DATA phase of entry 1
    do_reset(2);
    nack_entry = 1; nack_k = 1; nack_left = 1;
    model_init(1, 1, 1);
    wait_state(ST_DONE, "s2_done");
    check_log("s2");
    chk("s2_flags", {done, err}, 2'b10);
    chk("s2_nack_used", nack_left, 0);

    // S3: entry 1 always NACKs, random phase
    do_reset(2);
    nack_entry = 1; nack_k = $urandom_range(2, 0); nack_left = 100;
    model_init(1, nack_k, 100);
    wait_state(ST_ERR, "s3_err");
    repeat (40) @(negedge clk);
    check_log("s3");
    chk("s3_flags", {done, err, busy}, 3'b010);
    chk("s3_err_index", err_index, 1);
    chk("s3_state_held", dbg_state, ST_ERR);

    // S4: runtime write always NACKs, then a clean runtime write
    do_reset(2);
    model_init(-1, 0, 0);
    wait_state(ST_DONE, "s4_init");
    check_log("s4_init");
    obs_q.delete(); exp_q.delete();
    nack_rt = 1'b1; nack_k = $urandom_range(2, 0); nack_left = 100;
    ra = 8'($urandom); rd = 8'($urandom);
    model_entry(ra, rd, nack_k, 100, f);
    issue_upd(ra, rd);
    wait_upd_ack("s4a");
    wait_state(ST_DONE, "s4a_done");
    check_log("s4a");
    chk("s4a_flags", {done, err}, 2'b11);
    chk("s4a_err_index", err_index, 8'hFF);
    obs_q.delete(); exp_q.delete();
    nack_rt = 1'b0; nack_left = 0;
    ra = 8'($urandom); rd = 8'($urandom);
    model_entry(ra, rd, 0, 0, f);
    issue_upd(ra, rd);
    wait_upd_ack("s4b");
    wait_state(ST_DONE, "s4b_done");
    check_log("s4b");
    chk("s4b_flags", {done, err}, 2'b11);

    // S5: reset pulse while entry 5 waits in ADDR
    do_reset(2);
    hold5 = 1'b1;
    begin
      int i;
      for (i = 0; i < LIM; i++) begin
        @(negedge clk);
        if (dbg_state === ST_ADDR && tbl_addr == 8'd5) break;
      end
      chk("s5_addr5_reached", i < LIM, 1);
    end
    repeat ($urandom_range(5, 1)) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s5_rst_ctl", {start, stop, upd_ack, done, busy, err}, 0);
    chk("s5_rst_bytes", {wr_data, err_index, tbl_addr}, 0);
    chk("s5_rst_state", dbg_state, ST_BOOT);
    hold5 = 1'b0;
    obs_q.delete(); exp_q.delete();
    boot_cnt = 1;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (start === 1'b1) break;
      boot_cnt++;
    end
    chk("s5_boot_len", boot_cnt, BC);
    chk("s5_restart_idx", tbl_addr, 0);
    model_init(-1, 0, 0);
    wait_state(ST_DONE, "s5_done");
    check_log("s5");
    chk("s5_flags", {done, err}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_cfg_sequencer.md
OV7670_CFG_SEQUENCER -- requirements
Module: ov7670_cfg_sequencer

Interface
REQ-001 SHALL have parameter MSG_LAST, default 78: index of last table entry written during init.
REQ-002 SHALL have parameter BOOT_CYCLES, default 67108864: power-up wait before first transaction.
REQ-003 SHALL have parameter GAP_CYCLES, default 65536: idle gap after every transaction.
REQ-004 SHALL have parameter MAX_RETRY, default 3: retries per transaction after NACK.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-007 SHALL have port tbl_addr  output  8: table index being read.
REQ-008 SHALL have port tbl_data  input  16: combinational table word; [15:8] register address, [7:0] value.
REQ-009 SHALL have port start  output  1: one-cycle pulse that begins an SCCB transaction.
REQ-010 SHALL have port stop  output  1: one-cycle pulse that ends an SCCB transaction.
REQ-011 SHALL have port wr_data  output  8: byte for the I2C master; 0 when not presenting.
REQ-012 SHALL have port ack  input  2: ack[1] pulses at the 9th bit; ack[0]=1 means ACK, 0 means NACK.
REQ-013 SHALL have port i2c_idle  input  1: I2C master is idle.
REQ-014 SHALL have port upd_req  input  1: runtime write request; held high until upd_ack.
REQ-015 SHALL have port upd_addr, upd_data  input  8 each: runtime register address and value.
REQ-016 SHALL have port upd_ack  output  1: one-cycle pulse when a request is latched.
REQ-017 SHALL have port done  output  1: init sequence complete.
REQ-018 SHALL have port busy  output  1: transaction in progress (START through GAP).
REQ-019 SHALL have port err  output  1: sticky; set when retries are exhausted.
REQ-020 SHALL have port err_index  output  8: tbl_addr of failing init entry, or 8'hFF for a runtime entry.

Function
REQ-021 SHALL implement states BOOT, START, ADDR, DATA, STOP, GAP, DONE, ERR.
REQ-022 BOOT SHALL count BOOT_CYCLES, then go to START with index 0.
REQ-023 START SHALL assert start=1 and wr_data=8'h42 for exactly one cycle, then go to ADDR.
REQ-024 ADDR SHALL wait for ack==2'b11, then present tbl_data[15:8] (or the latched runtime address) for one cycle and go to DATA.
REQ-025 DATA SHALL wait for ack==2'b11, then present tbl_data[7:0] (or the latched runtime value) for one cycle and go to STOP.
REQ-026 STOP SHALL wait for ack==2'b11, pulse stop for one cycle, clear the retry count and go to GAP.
REQ-027 ack==2'b10 in ADDR, DATA or STOP SHALL pulse stop, increment the retry count and go to GAP, keeping the same entry.
REQ-028 GAP SHALL count GAP_CYCLES and then wait for i2c_idle before leaving.
REQ-029 On leaving GAP after success: if index==MSG_LAST go to DONE and set done; otherwise increment index and go to START.
REQ-030 On leaving GAP after NACK with retry count <= MAX_RETRY, the block SHALL go to START for the same entry.
REQ-031 Retry count > MAX_RETRY on an init entry SHALL set err, set err_index=index and go to ERR; ERR holds until reset.
REQ-032 Retry count > MAX_RETRY on a runtime entry SHALL set err, set err_index=8'hFF and return to DONE.
REQ-033 In DONE, upd_req=1 SHALL latch upd_addr and upd_data, pulse upd_ack the same cycle and go to START.
REQ-034 After a runtime transaction, GAP SHALL return to DONE; done stays 1.
REQ-035 upd_req asserted before DONE SHALL NOT be acknowledged until DONE is reached.
REQ-036 Only one runtime request SHALL be latched per transaction; requests are never dropped.
REQ-037 tbl_addr SHALL equal the current index; it is stable for the whole transaction.
REQ-038 ack pulses in BOOT, GAP, DONE or ERR SHALL be ignored.
REQ-039 busy SHALL be 1 in START, ADDR, DATA, STOP and GAP, and 0 otherwise.
REQ-040 Counters SHALL be 27 bits; the retry counter SHALL saturate at MAX_RETRY+1.

Reset
REQ-041 rst_n=0 at a clock edge SHALL force BOOT and clear index, counters, latched request and pending pulses.
REQ-042 rst_n=0 SHALL drive start=0, stop=0, wr_data=0, upd_ack=0, done=0, busy=0, err=0 and err_index=0.
REQ-043 Reset during a transaction SHALL abort it without a stop pulse; init restarts from BOOT.

Verification
REQ-044 Nominal init (MSG_LAST=2, BOOT_CYCLES=16, GAP_CYCLES=8, all ACK): 3 start pulses with wr_data 8'h42, 3 address/value pairs in table order, done=1 after the third GAP.
REQ-045 NACK on DATA of entry 1, then ACK: stop pulse, GAP, entry 1 retransmitted once, done=1, err=0.
REQ-046 Entry 1 always NACK, MAX_RETRY=3: 4 attempts, then err=1, err_index=1, state ERR, done=0.
REQ-047 upd_req with 8'h55/8'h40 raised during BOOT: upd_ack only after done=1; transaction bytes 8'h42, 8'h55, 8'h40; block returns to DONE.
REQ-048 Runtime transaction always NACK: err=1, err_index=8'hFF, done stays 1, next upd_req accepted.
REQ-049 rst_n low for 1 cycle mid-ADDR of entry 5: all outputs 0 next cycle; sequence restarts at entry 0 after BOOT_CYCLES.
